// File: rtl/add_seg_seq.sv
// add_seg_seq: segment-serial adder that handles segw bits of A+B+CI per cycle.
//   Ports: CLK, RSTN (sync, active-low); A/B/CI in with IN_VALID/IN_READY;
//   S/CO/V registered out with OUT_VALID/OUT_READY.
package lau_pkg;
  typedef enum logic {FAST, SLOW} speed_e;
endpackage

// lau_pre_and_or: carry prefix (GO[i] = GI[i] | PI[i] & GO[i-1], GO[-1] = CI).
//   FAST selects a log-depth parallel prefix and SLOW selects a ripple chain.
module lau_pre_and_or #(
  parameter int W = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [W-1:0] GI,
  input  logic [W-1:0] PI,
  input  logic         CI,
  output logic [W-1:0] GO
);
  function automatic logic [W-1:0] pfx(input logic [W-1:0] gi, pi, input logic ci);
    logic [W-1:0] g, p, gn, pn;
    // Fold the carry-in into bit 0 so that the prefix needs no extra column.
    g = gi | W'(pi[0] & ci);
    p = pi;
    for (int d = 1; d < W; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return g;
  endfunction
  function automatic logic [W-1:0] rip(input logic [W-1:0] gi, pi, input logic ci);
    logic [W-1:0] g;
    logic c;
    c = ci;
    for (int i = 0; i < W; i++) begin
      g[i] = gi[i] | (pi[i] & c);
      c = g[i];
    end
    return g;
  endfunction
  assign GO = (speed == lau_pkg::FAST) ? pfx(GI, PI, CI) : rip(GI, PI, CI);
endmodule

module add_seg_seq #(
  parameter int width = 32,
  parameter int segw = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [width-1:0] S,
  output logic             CO,
  output logic             V,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);
  localparam int NSEG = width / segw;
  localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] seg_q, seg_d;
  logic c_q, c_d, co_q, co_d, v_q, v_d;
  logic [width-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [segw-1:0] ak, bk, go;
  logic [segw:0] cc;
  assign ak = a_q[int'(seg_q) * segw +: segw];
  assign bk = b_q[int'(seg_q) * segw +: segw];
  lau_pre_and_or #(.W(segw), .speed(speed)) u_pfx (
    .GI(ak & bk),
    .PI(ak ^ bk),
    .CI(c_q),
    .GO(go)
  );
  // cc[i] is the carry into segment bit i; cc[segw] is the segment carry-out.
  assign cc = {go, c_q};
  always_comb begin
    state_d = state_q;
    seg_d = seg_q;
    c_d = c_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    co_d = co_q;
    v_d = v_q;
    if (state_q == IDLE && IN_VALID) begin
      a_d = A;
      b_d = B;
      c_d = CI;
      seg_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      s_d[int'(seg_q) * segw +: segw] = (ak ^ bk) ^ cc[segw-1:0];
      c_d = cc[segw];
      if (seg_q == SW'(NSEG - 1)) begin
        co_d = cc[segw];
        v_d = cc[segw] ^ cc[segw-1];
        state_d = DONE;
      end else begin
        seg_d = seg_q + 1'b1;
      end
    end else if (state_q == DONE && OUT_READY) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      seg_q <= '0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      co_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q <= seg_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      co_q <= co_d;
      v_q <= v_d;
    end
  end
  assign IN_READY = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign S = s_q;
  assign CO = co_q;
  assign V = v_q;
endmodule

// File: tb/tb_add_seg_seq.sv
// tb_add_seg_seq: directed and back-to-back checks of add_seg_seq against a sum model.
module tb_add_seg_seq;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RSTN;
  logic [31:0] A, B, S;
  logic CI, IN_VALID, IN_READY, CO, V, OUT_VALID, OUT_READY;
  logic [7:0] a8, b8, s8;
  logic ci8, iv8, ir8, co8, v8, ov8, or8;
  add_seg_seq #(.width(32), .segw(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .A(A), .B(B), .CI(CI), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .S(S), .CO(CO), .V(V), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );
  add_seg_seq #(.width(8), .segw(8)) dut8 (
    .CLK(CLK), .RSTN(RSTN), .A(a8), .B(b8), .CI(ci8), .IN_VALID(iv8),
    .IN_READY(ir8), .S(s8), .CO(co8), .V(v8), .OUT_VALID(ov8),
    .OUT_READY(or8)
  );
  typedef struct packed {
    logic [31:0] s;
    logic co;
    logic v;
  } res_t;
  res_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [31:0] a, b, input logic ci);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b} + 33'(ci);
    model.s = t[31:0];
    model.co = t[32];
    model.v = (a[31] == b[31]) && (t[31] != a[31]);
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [31:0] a, b, input logic ci);
    int n = 0;
    while (!IN_READY && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 64'(IN_READY), 1);
    A = a;
    B = b;
    CI = ci;
    IN_VALID = 1'b1;
    tick();
    sb.push_back(model(a, b, ci));
    IN_VALID = 1'b0;
  endtask
  task automatic compare(input string tag);
    res_t e;
    check({tag, "_sb"}, 64'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_s"}, 64'(S), 64'(e.s));
      check({tag, "_co"}, 64'(CO), 64'(e.co));
      check({tag, "_v"}, 64'(V), 64'(e.v));
    end
  endtask
  task automatic collect(input string tag, input int lat);
    int n = 0;
    while (!OUT_VALID && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    compare(tag);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] ss;
    logic sco, sv;
    int n, got, issued, last, cyc;
    RSTN = 1'b0;
    A = '0; B = '0; CI = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    a8 = '0; b8 = '0; ci8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    repeat (3) tick();
    RSTN = 1'b1;
    check("rst_in_ready", 64'(IN_READY), 1);
    check("rst_out_valid", 64'(OUT_VALID), 0);
    check("rst_s", 64'(S), 0);
    check("rst_co", 64'(CO), 0);
    check("rst_v", 64'(V), 0);
    send(32'hFFFF_FFFF, 32'h1, 1'b0);
    collect("wrap", 4);
    tick();
    send(32'h7FFF_FFFF, 32'h1, 1'b0);
    collect("ovf_pos", 4);
    tick();
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    collect("ovf_neg", 4);
    tick();
    OUT_READY = 1'b0;
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    collect("stall", 4);
    ss = S; sco = CO; sv = V;
    for (int i = 0; i < 10; i++) begin
      IN_VALID = i[0];
      A = $urandom;
      B = $urandom;
      tick();
      check("stall_ov", 64'(OUT_VALID), 1);
      check("stall_ir", 64'(IN_READY), 0);
      check("stall_s", 64'(S), 64'(ss));
      check("stall_co", 64'(CO), 64'(sco));
      check("stall_v", 64'(V), 64'(sv));
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("release_ir", 64'(IN_READY), 1);
    check("release_ov", 64'(OUT_VALID), 0);
    check("release_s_hold", 64'(S), 64'(ss));
    send(32'h0000_0055, 32'h0000_0066, 1'b0);
    tick();
    tick();
    RSTN = 1'b0;
    IN_VALID = 1'b1;
    tick();
    RSTN = 1'b1;
    IN_VALID = 1'b0;
    sb.delete();
    check("abort_ir", 64'(IN_READY), 1);
    check("abort_ov", 64'(OUT_VALID), 0);
    check("abort_s", 64'(S), 0);
    check("abort_co", 64'(CO), 0);
    check("abort_v", 64'(V), 0);
    send(32'd3, 32'd4, 1'b1);
    collect("after_abort", 4);
    check("after_abort_s8", 64'(S), 8);
    tick();
    check("n1_ir", 64'(ir8), 1);
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b1; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 10) begin
      tick();
      n++;
    end
    check("n1_lat", 64'(n), 1);
    check("n1_s", 64'(s8), 64'h01);
    check("n1_co", 64'(co8), 1);
    check("n1_v", 64'(v8), 0);
    got = 0; issued = 0; last = -1; cyc = 0;
    OUT_READY = 1'b1;
    while (got < 1000 && cyc < 7000) begin
      if (OUT_VALID) begin
        compare("b2b");
        if (last >= 0) check("b2b_gap", 64'(cyc - last), 6);
        last = cyc;
        got++;
      end
      if (IN_READY) begin
        if (issued < 1000) begin
          A = $urandom;
          B = $urandom;
          CI = 1'($urandom_range(0, 1));
          IN_VALID = 1'b1;
          sb.push_back(model(A, B, CI));
          issued++;
        end else begin
          IN_VALID = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    IN_VALID = 1'b0;
    check("b2b_count", 64'(got), 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_seg_seq.md
ADD_SEG_SEQ -- requirements
Module: add_seg_seq

Interface
REQ-001 Parameter: width, 32, total operand width in bits.
REQ-002 Parameter: segw, 8, segment width processed per cycle; width SHALL be an integer multiple of segw, segw >= 1.
REQ-003 Parameter: speed, lau_pkg::FAST, performance parameter passed to the internal prefix AND-OR structure.
REQ-004 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Port: RSTN  input  1  reset, synchronous, active-low.
REQ-006 Port: A, B  input  width  operands, sampled on input handshake.
REQ-007 Port: CI  input  1  carry-in, sampled on input handshake.
REQ-008 Port: IN_VALID / IN_READY  input / output  1  input handshake; transfer when both high on a rising edge.
REQ-009 Port: S  output  width  registered sum.
REQ-010 Port: CO  output  1  registered carry-out of bit width-1.
REQ-011 Port: V  output  1  registered two's-complement overflow (carry into MSB XOR CO).
REQ-012 Port: OUT_VALID / OUT_READY  output / input  1  output handshake.

Function
REQ-013 NSEG = width/segw; segment counter width = max(1, ceil(log2(NSEG))).
REQ-014 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-015 IN_READY SHALL be 1 exactly in IDLE; OUT_VALID SHALL be 1 exactly in DONE; both registered-state decodes, no combinational path from IN_VALID or OUT_READY.
REQ-016 IDLE & IN_VALID: latch A, B; carry register := CI; seg := 0; go to RUN.
REQ-017 RUN, per cycle, segment k = seg: GI = A[k]&B[k], PI = A[k]^B[k], fed with carry register to one segw-wide prefix AND-OR instance with fast carry-in.
REQ-018 Segment sum bit i = PI[i] ^ c_i, c_0 = carry register, c_i = GO[i-1] for i>0; result written to S[k*segw +: segw]; carry register := GO[segw-1].
REQ-019 RUN with seg = NSEG-1: CO := GO[segw-1]; V := GO[segw-1] ^ c_(segw-1) of that segment (c_0 = carry register when segw = 1); go to DONE; otherwise seg := seg+1.
REQ-020 Latency: OUT_VALID rises exactly NSEG cycles after the accepting edge; NSEG = 1 gives 1-cycle latency.
REQ-021 DONE: S, CO, V held stable while OUT_READY = 0; on OUT_READY = 1 go to IDLE; S/CO/V keep last value after leaving DONE.
REQ-022 IN_VALID during RUN or DONE SHALL be ignored (no overlap); next accept earliest on the cycle after output handshake.
REQ-023 Throughput: one operation per NSEG+2 cycles with OUT_READY and IN_VALID held high.
REQ-024 Segments not yet processed in RUN SHALL leave S bits unchanged from their prior value; S only valid when OUT_VALID = 1.
REQ-025 Arithmetic is modulo 2^width; {CO,S} = A + B + CI exactly.

Reset
REQ-026 RSTN = 0 at a rising edge: state := IDLE, seg := 0, carry register := 0, S := 0, CO := 0, V := 0, operand registers := 0; IN_READY = 1, OUT_VALID = 0 from the next cycle.
REQ-027 Reset during RUN or DONE SHALL abort the operation; no partial result is presented; RSTN dominates IN_VALID in the same cycle.

Verification (width=32, segw=8)
REQ-028 A=0xFFFFFFFF, B=0x00000001, CI=0 -> S=0x00000000, CO=1, V=0, OUT_VALID exactly 4 cycles after accept.
REQ-029 A=0x7FFFFFFF, B=0x00000001, CI=0 -> S=0x80000000, CO=0, V=1; A=0x80000000, B=0x80000000, CI=1 -> S=0x00000001, CO=1, V=1.
REQ-030 OUT_READY held 0 for 10 cycles in DONE, IN_VALID toggling -> S/CO/V/OUT_VALID stable, IN_READY=0, no new accept; release -> IDLE next cycle.
REQ-031 RSTN=0 at RUN seg=2 -> next cycle IDLE, S=0, CO=0, V=0, OUT_VALID=0; new op A=3, B=4, CI=1 -> S=8.
REQ-032 Back-to-back, IN_VALID and OUT_READY held 1, 1000 random operands with random CI -> every result matches A+B+CI, one result per 6 cycles.
REQ-033 Parameterization width=segw=8: A=0xFF, B=0x01, CI=1 -> S=0x01, CO=1, V=0, OUT_VALID 1 cycle after accept.
